// File: rtl/apb_master_pkg.sv
// Shared types and default widths for the APB master bridge.
// Imported by apb_master_bridge_if and apb_master_bridge.
package apb_master_pkg;

  localparam int APB_ADDR_W         = 5;
  localparam int APB_DATA_W         = 32;
  localparam int APB_TIMEOUT_CYCLES = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_mst_state_t;

  // Width of a counter that must reach limit-1; never narrower than one bit.
  function automatic int wait_cnt_width(input int limit);
    return (limit > 2) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Request-bus and APB signal bundle for the APB master bridge.
// master = bridge view, slave = requester/peripheral environment view.
interface apb_master_bridge_if
  import apb_master_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wd;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rd;
  logic              resp_err;

  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pwrite;
  logic              psel;
  logic              penable;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wd,
    input  prdata, pready, pslverr,
    output req_ready, resp_valid, resp_rd, resp_err,
    output paddr, pwdata, pwrite, psel, penable
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wd,
    output prdata, pready, pslverr,
    input  req_ready, resp_valid, resp_rd, resp_err,
    input  paddr, pwdata, pwrite, psel, penable
  );

endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding request-bus to APB requester bridge (IDLE -> SETUP -> ACCESS).
// Optional ACCESS-phase timeout is built only when APB_TIMEOUT_EN is defined.
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
  input  logic                clk_i,
  input  logic                rst_i,
  apb_master_bridge_if.master bus
);

  apb_mst_state_t    state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [DATA_W-1:0] resp_rd_q, resp_rd_d;
  logic              timeout_hit_s;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = wait_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Wait counter: zero outside ACCESS so it is clear on entry, counts stalled ACCESS cycles.
  always_comb begin
    wait_cnt_d    = wait_cnt_q;
    timeout_hit_s = 1'b0;
    if (state_q == ACCESS) begin
      if (bus.pready) begin
        wait_cnt_d = '0;
      end else if (wait_cnt_q == WAIT_LIMIT) begin
        timeout_hit_s = 1'b1;
        wait_cnt_d    = '0;
      end else begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
    end else begin
      wait_cnt_d = '0;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Next-state and registered-output decode.
  always_comb begin
    state_d      = state_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    pwrite_d     = pwrite_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rd_d    = resp_rd_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          paddr_d  = bus.req_addr;
          pwdata_d = bus.req_wd;
          pwrite_d = bus.req_write;
          state_d  = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // pready beats the timeout when both land in the same cycle.
        if (bus.pready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_err_d   = bus.pslverr;
          if (!pwrite_q) begin
            resp_rd_d = bus.prdata;
          end else begin
            resp_rd_d = resp_rd_q;
          end
        end else if (timeout_hit_s) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rd_d    = '0;
        end else begin
          state_d = ACCESS;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    psel_d      = (state_d != IDLE);
    penable_d   = (state_d == ACCESS);
    req_ready_d = (state_d == IDLE);
  end

  // State and output registers; reset aborts any transfer without a response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pwrite_q     <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rd_q    <= '0;
    end else begin
      state_q      <= state_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      pwrite_q     <= pwrite_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rd_q    <= resp_rd_d;
    end
  end

  assign bus.paddr      = paddr_q;
  assign bus.pwdata     = pwdata_q;
  assign bus.pwrite     = pwrite_q;
  assign bus.psel       = psel_q;
  assign bus.penable    = penable_q;
  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rd    = resp_rd_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed spec scenarios then randomized transfers.
// The bench acts as requester and APB slave; APB_TIMEOUT_EN enables the timeout scenario.
module tb_apb_master_bridge;
  import apb_master_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam int NRAND = 24;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apb_master_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic slave_noise();
    bus.pready  = 1'($urandom_range(0, 1));
    bus.pslverr = 1'($urandom_range(0, 1));
    bus.prdata  = $urandom;
  endtask

  // One transfer seen from both sides. Called at posedge+1 with the bridge idle.
  task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                      input int waits, input logic [DW-1:0] rdata, input logic err,
                      input bit chain, input logic n_wr, input logic [AW-1:0] n_addr,
                      input logic [DW-1:0] n_wd);
    int cyc = 0;
    int ps  = 0;
    int pe  = 0;
    bit got = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wd    = wd;
    chk("req_ready_offer", 32'(bus.req_ready), 32'd1);
    while (!got && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
      slave_noise();
      if (cyc == 1) begin
        if (chain) begin
          bus.req_write = n_wr;
          bus.req_addr  = n_addr;
          bus.req_wd    = n_wd;
        end else begin
          bus.req_valid = 1'b0;
          bus.req_write = 1'($urandom_range(0, 1));
          bus.req_addr  = AW'($urandom);
          bus.req_wd    = $urandom;
        end
        chk("setup_phase", 32'({bus.psel, bus.penable}), 32'd2);
        chk("busy_not_ready", 32'(bus.req_ready), 32'd0);
      end
      if (bus.resp_valid) begin
        got = 1'b1;
        if (!wr) exp_rd = rdata;
        chk("latency", 32'(cyc), 32'(3 + waits));
        chk("resp_err", 32'(bus.resp_err), 32'(err));
        chk("resp_rd", bus.resp_rd, exp_rd);
        chk("psel_drop", 32'({bus.psel, bus.penable}), 32'd0);
        chk("ready_at_resp", 32'(bus.req_ready), 32'd1);
      end else if (bus.psel) begin
        ps++;
        if (bus.penable) pe++;
        chk("paddr", 32'(bus.paddr), 32'(addr));
        chk("pwdata", bus.pwdata, wd);
        chk("pwrite", 32'(bus.pwrite), 32'(wr));
        if (bus.penable) begin
          if (pe > waits) begin
            bus.pready  = 1'b1;
            bus.pslverr = err;
            bus.prdata  = rdata;
          end else begin
            bus.pready = 1'b0;
          end
        end
      end
    end
    chk("resp_seen", 32'(got), 32'd1);
    chk("psel_cycles", 32'(ps), 32'(waits + 2));
    chk("penable_cycles", 32'(pe), 32'(waits + 1));
  endtask

  logic          r_wr   [NRAND];
  logic [AW-1:0] r_addr [NRAND];
  logic [DW-1:0] r_wd   [NRAND];

  initial begin
    int seen;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wd    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    bus.prdata    = '0;
    exp_rd        = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_psel_pen", 32'({bus.psel, bus.penable, bus.pwrite}), 32'd0);
    chk("rst_resp", 32'({bus.resp_valid, bus.resp_err}), 32'd0);
    chk("rst_paddr", 32'(bus.paddr), 32'd0);
    chk("rst_pwdata", bus.pwdata, 32'd0);
    chk("rst_resp_rd", bus.resp_rd, 32'd0);

    // Zero-wait write, three-wait read, slave error then clean transfer
    xfer(1'b1, 5'h04, 32'hDEADBEEF, 0, 32'h0, 1'b0, 1'b0, 1'b0, 5'h0, 32'h0);
    xfer(1'b0, 5'h08, 32'h11111111, 3, 32'h0000005A, 1'b0, 1'b0, 1'b0, 5'h0, 32'h0);
    xfer(1'b0, 5'h1F, 32'h0, 1, 32'hCAFE0001, 1'b1, 1'b0, 1'b0, 5'h0, 32'h0);
    xfer(1'b1, 5'h02, 32'h01234567, 0, 32'h0, 1'b0, 1'b0, 1'b0, 5'h0, 32'h0);

    // Back-to-back writes with req_valid held
    xfer(1'b1, 5'h00, 32'hA5A5A5A5, 0, 32'h0, 1'b0, 1'b1, 1'b1, 5'h10, 32'h5A5A5A5A);
    xfer(1'b1, 5'h10, 32'h5A5A5A5A, 0, 32'h0, 1'b0, 1'b0, 1'b0, 5'h0, 32'h0);

    // Reset during a waited read
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 5'h08;
    bus.pready    = 1'b0;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_access", 32'({bus.psel, bus.penable}), 32'd3);
    @(posedge clk); #1 rst = 1'b1;
    bus.pready  = 1'b1;
    bus.prdata  = 32'hBAD0BAD0;
    @(posedge clk); #1 rst = 1'b0;
    chk("rst_abort_psel", 32'({bus.psel, bus.penable}), 32'd0);
    chk("rst_abort_resp", 32'(bus.resp_valid), 32'd0);
    chk("rst_abort_ready", 32'(bus.req_ready), 32'd1);
    exp_rd = '0;
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.resp_valid) seen++;
    end
    chk("rst_no_resp", 32'(seen), 32'd0);
    chk("rst_abort_rd", bus.resp_rd, exp_rd);

`ifdef APB_TIMEOUT_EN
    // Stuck slave: response 8 cycles after ACCESS entry with error and zero data
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 5'h03;
    bus.pready    = 1'b0;
    seen = 0;
    begin
      int cyc = 0;
      int pe  = 0;
      while (seen == 0 && cyc < 40) begin
        @(posedge clk); #1;
        cyc++;
        bus.req_valid = 1'b0;
        bus.pready    = 1'b0;
        if (bus.resp_valid) seen = cyc;
        else if (bus.penable) pe++;
      end
      chk("to_latency", 32'(seen), 32'(2 + TO));
      chk("to_penable", 32'(pe), 32'(TO));
      chk("to_err", 32'(bus.resp_err), 32'd1);
      chk("to_rd", bus.resp_rd, 32'd0);
      chk("to_psel", 32'({bus.psel, bus.penable}), 32'd0);
      exp_rd = '0;
    end
`endif

    // Randomized transfers
    for (int i = 0; i < NRAND; i++) begin
      r_wr[i]   = 1'($urandom_range(0, 1));
      r_addr[i] = AW'($urandom);
      r_wd[i]   = $urandom;
    end
    for (int i = 0; i < NRAND; i++) begin
      bit chain;
      int nx;
      chain = (i < NRAND - 1) && ($urandom_range(0, 1) == 1);
      nx    = (i < NRAND - 1) ? i + 1 : i;
      xfer(r_wr[i], r_addr[i], r_wd[i], int'($urandom_range(0, 4)), $urandom,
           1'($urandom_range(0, 1)), chain, r_wr[nx], r_addr[nx], r_wd[nx]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
